// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate-generation unit for the decode/execute boundary.
// A raw HWL-bit immediate field is widened to WL bits according to a 2-bit
// extension mode, then carried through DEPTH register stages that follow
// the pipeline's global Flush/Stall controls. The operand therefore reaches
// EX in step with its instruction. Outputs are the last stage's flops only.
module imm_ext_pipe #(
  parameter int HWL   = 16,
  parameter int WL    = 32,
  parameter int DEPTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [HWL-1:0] Imm,
  input  logic [1:0]     Mode,
  input  logic           Stall,
  input  logic           Flush,
  output logic           out_valid,
  output logic [WL-1:0]  SImm
);

  // Extension modes as they arrive on the Mode port.
  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  // Reject parameter combinations the datapath cannot represent.
  if (HWL < 2 || HWL > WL) begin : g_bad_hwl
    $error("imm_ext_pipe: HWL must lie in 2..WL");
  end
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("imm_ext_pipe: DEPTH must lie in 1..4");
  end

  // Widen one immediate field. Size casts do the replication: a cast of a
  // signed operand sign-extends, a cast of an unsigned one zero-fills, and
  // both degenerate to a plain copy when HWL equals WL, so no part-select of
  // an empty upper range is ever formed.
  function automatic logic [WL-1:0] ext_imm(input logic [HWL-1:0] imm,
                                            input mode_e          mode);
    logic [WL-1:0] sext;
    logic [WL-1:0] zext;
    sext = WL'($signed(imm));
    zext = WL'(imm);
    case (mode)
      MODE_SIGN:   ext_imm = sext;
      MODE_ZERO:   ext_imm = zext;
      MODE_UPPER:  ext_imm = zext << (WL - HWL);
      MODE_BRANCH: ext_imm = sext << 2;
      default:     ext_imm = sext;
    endcase
  endfunction

  logic [WL-1:0]    ext_s;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] valid_q;
  logic [WL-1:0]    data_d [DEPTH];
  logic [WL-1:0]    data_q [DEPTH];

  // Next-state for every stage: Flush beats Stall beats advance.
  always_comb begin
    ext_s = ext_imm(Imm, mode_e'(Mode));
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k];
      data_d[k]  = data_q[k];
    end
    if (Flush) begin
      // Kill everything in flight; the input of this cycle is dropped too.
      for (int k = 0; k < DEPTH; k++) begin
        valid_d[k] = 1'b0;
        data_d[k]  = {WL{1'b0}};
      end
    end else if (Stall) begin
      // Hold every stage; upstream keeps presenting the stalled instruction.
      for (int k = 0; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k];
        data_d[k]  = data_q[k];
      end
    end else begin
      // Advance one position. Bubbles always carry zero data.
      valid_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = ext_s;
      end else begin
        data_d[0] = {WL{1'b0}};
      end
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  // Stage registers; reset clears every entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= {WL{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  // The last stage drives the outputs straight from its flops.
  assign out_valid = valid_q[DEPTH-1];
  assign SImm      = data_q[DEPTH-1];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: two instances (HWL=16/DEPTH=2 and HWL=32/DEPTH=1,
// both WL=32) share control inputs. A reference model pushes expected
// operands into per-instance scoreboards; a negedge monitor compares.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  mode;
  logic        stall;
  logic        flush;
  logic [15:0] imm_a;
  logic [31:0] imm_b;
  logic        a_ov;
  logic [31:0] a_so;
  logic        b_ov;
  logic [31:0] b_so;

  int checks   = 0;
  int failures = 0;
  int adv      = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
    bit          seen;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  always #5 clk = ~clk;

  imm_ext_pipe #(.HWL(16), .WL(32), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .Imm(imm_a), .Mode(mode),
    .Stall(stall), .Flush(flush), .out_valid(a_ov), .SImm(a_so)
  );

  imm_ext_pipe #(.HWL(32), .WL(32), .DEPTH(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .Imm(imm_b), .Mode(mode),
    .Stall(stall), .Flush(flush), .out_valid(b_ov), .SImm(b_so)
  );

  // Reference extension computed with plain integer arithmetic.
  function automatic logic [31:0] ref_ext(input logic [31:0] imm, input int hwl,
                                          input logic [1:0] m);
    longint one;
    longint u;
    longint s;
    longint r;
    one = 1;
    u   = longint'(imm);
    if (u >= (one << (hwl - 1))) s = u - (one << hwl);
    else                         s = u;
    case (m)
      2'd0:    r = s;
      2'd1:    r = u;
      2'd2:    r = u * (one << (32 - hwl));
      default: r = s * 4;
    endcase
    r = r & 64'h0000_0000_FFFF_FFFF;
    return r[31:0];
  endfunction

  // Model: count advancing edges and queue each accepted entry with the
  // advance count at which it must be on the outputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_a.delete();
      sb_b.delete();
    end else if (flush) begin
      sb_a.delete();
      sb_b.delete();
    end else if (!stall) begin
      adv <= adv + 1;
      if (in_valid) begin
        sb_a.push_back('{ref_ext({16'h0000, imm_a}, 16, mode), adv + 2, 1'b0});
        sb_b.push_back('{ref_ext(imm_b, 32, mode), adv + 1, 1'b0});
      end
    end
  end

  // Monitor for instance A.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb_a.size() > 0 && sb_a[0].due < adv) begin
        checks++;
        if (!sb_a[0].seen) begin
          failures++;
          $display("FAIL a_lost: entry %h never shown (due %0d, now %0d)",
                   sb_a[0].data, sb_a[0].due, adv);
        end
        void'(sb_a.pop_front());
      end
      checks++;
      if (sb_a.size() > 0 && sb_a[0].due == adv) begin
        if (a_ov !== 1'b1 || a_so !== sb_a[0].data) begin
          failures++;
          $display("FAIL a_data: got v=%b d=%h want v=1 d=%h", a_ov, a_so, sb_a[0].data);
        end
        sb_a[0].seen = 1'b1;
      end else if (a_ov !== 1'b0 || a_so !== 32'h0000_0000) begin
        failures++;
        $display("FAIL a_idle: got v=%b d=%h want v=0 d=00000000", a_ov, a_so);
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb_b.size() > 0 && sb_b[0].due < adv) begin
        checks++;
        if (!sb_b[0].seen) begin
          failures++;
          $display("FAIL b_lost: entry %h never shown (due %0d, now %0d)",
                   sb_b[0].data, sb_b[0].due, adv);
        end
        void'(sb_b.pop_front());
      end
      checks++;
      if (sb_b.size() > 0 && sb_b[0].due == adv) begin
        if (b_ov !== 1'b1 || b_so !== sb_b[0].data) begin
          failures++;
          $display("FAIL b_data: got v=%b d=%h want v=1 d=%h", b_ov, b_so, sb_b[0].data);
        end
        sb_b[0].seen = 1'b1;
      end else if (b_ov !== 1'b0 || b_so !== 32'h0000_0000) begin
        failures++;
        $display("FAIL b_idle: got v=%b d=%h want v=0 d=00000000", b_ov, b_so);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] ia,
                       input logic [31:0] ib, input logic s, input logic f);
    @(posedge clk);
    #1;
    in_valid = v;
    mode     = m;
    imm_a    = ia;
    imm_b    = ib;
    stall    = s;
    flush    = f;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    mode     = 2'b00;
    stall    = 1'b0;
    flush    = 1'b0;
    imm_a    = 16'h0000;
    imm_b    = 32'h0000_0000;
    #1;
    chk("reset_a_valid", {31'd0, a_ov}, 32'd0);
    chk("reset_a_data", a_so, 32'd0);
    chk("reset_b_valid", {31'd0, b_ov}, 32'd0);
    chk("reset_b_data", b_so, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Directed extension examples, back to back.
    drive(1'b1, 2'b00, 16'hFFFE, 32'h1234_5678, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 16'h8001, 32'h8000_0001, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 16'h1234, 32'hDEAD_BEEF, 1'b0, 1'b0);
    @(negedge clk);
    chk("sign_ffff_fffe", a_so, 32'hFFFF_FFFE);
    chk("sign_valid", {31'd0, a_ov}, 32'd1);
    drive(1'b1, 2'b11, 16'hFFFF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    chk("zero_0000_8001", a_so, 32'h0000_8001);
    chk("zero_valid_consecutive", {31'd0, a_ov}, 32'd1);
    chk("upper_w32_deadbeef", b_so, 32'hDEAD_BEEF);
    drive(1'b1, 2'b11, 16'h7FFF, 32'h4000_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("upper_1234", a_so, 32'h1234_0000);
    drive(1'b0, 2'b00, 16'h0000, 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("branch_ffff", a_so, 32'hFFFF_FFFC);
    drive(1'b0, 2'b00, 16'h0000, 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("branch_7fff", a_so, 32'h0001_FFFC);
    chk("bubble_b_valid", {31'd0, b_ov}, 32'd0);
    chk("bubble_b_data", b_so, 32'd0);

    // Stall for three cycles with a fresh instruction on the input.
    drive(1'b1, 2'b00, 16'h0101, 32'h0000_0101, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 16'h0202, 32'h0000_0202, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 16'h0303, 32'h0000_0303, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 2'b01, 16'hAAAA, 32'hAAAA_AAAA, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 2'b00, 16'h0000, 32'h0000_0000, 1'b0, 1'b0);

    // Flush together with Stall while two entries are in flight.
    drive(1'b1, 2'b00, 16'h1111, 32'h1111_1111, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 16'h2222, 32'h2222_2222, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 16'h3333, 32'h3333_3333, 1'b1, 1'b1);
    drive(1'b0, 2'b00, 16'h0000, 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_a_valid", {31'd0, a_ov}, 32'd0);
    chk("flush_a_data", a_so, 32'd0);
    chk("flush_b_valid", {31'd0, b_ov}, 32'd0);
    repeat (2) drive(1'b0, 2'b00, 16'h0000, 32'h0000_0000, 1'b0, 1'b0);

    // Asynchronous reset between edges while an output is live.
    drive(1'b1, 2'b00, 16'h8888, 32'h8888_8888, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 16'h9999, 32'h9999_9999, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 16'h4444, 32'h4444_4444, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_a_valid", {31'd0, a_ov}, 32'd0);
    chk("arst_a_data", a_so, 32'd0);
    chk("arst_b_valid", {31'd0, b_ov}, 32'd0);
    chk("arst_b_data", b_so, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    drive(1'b1, 2'b11, 16'hFFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 16'h0000, 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_b", b_so, 32'hFFFF_FFFC);
    drive(1'b0, 2'b00, 16'h0000, 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_a", a_so, 32'hFFFF_FFFC);

    // Randomised traffic with occasional stalls and flushes.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom), 16'($urandom), $urandom,
            ($urandom % 8) == 0, ($urandom % 20) == 0);
    end

    repeat (6) drive(1'b0, 2'b00, 16'h0000, 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("drain_a_empty", sb_a.size(), 32'd0);
    chk("drain_b_empty", sb_b.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
